// File: rtl/fetch_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants, opcodes and FSM state type for the fetch stage.
// Revision : 1.0 - initial release
// =============================================================================
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_I      = 7'b0010011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// =============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of {pc, instr} entries with flush and occupancy.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (r_count == '0);
  assign w_do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = push_i && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC, imem req/gnt/rvalid, buffered decode feed.
// Config   : FETCH_MISALIGN_CHK_EN enables sticky misaligned-redirect detection.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [6:0]      opcode_o,
  output logic            misalign_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic [CNT_W-1:0] w_out_next;
  logic [CNT_W-1:0] w_discard_next;
  logic [CNT_W:0]   w_inflight;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic [XLEN+31:0] w_fifo_rdata;
  logic [XLEN-1:0]  w_target;
  logic             w_fetch_block;
  logic             w_req;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_target      = redirect_pc_i;
  assign w_fetch_block = r_misalign;
  assign misalign_o    = r_misalign;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_misalign <= 1'b0;
    end else if (redirect_i) begin
      r_misalign <= |redirect_pc_i[1:0];
    end
  end
`else
  assign w_target      = redirect_pc_i & ~XLEN'(3);
  assign w_fetch_block = 1'b0;
  assign misalign_o    = 1'b0;
`endif

  // Buffer slots are reserved at grant time, so a response always has room.
  assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_req      = rst_ni && (r_state == RUN) && !w_fetch_block &&
                      (w_inflight < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_grant    = w_req && imem_gnt_i;
  assign w_out_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid_i);
  assign w_push     = imem_rvalid_i && !redirect_i && (r_discard == '0) && !w_fetch_block;
  assign w_pop      = instr_valid_o && instr_ready_i && !redirect_i;

  always_comb begin
    w_state_next   = r_state;
    w_discard_next = r_discard;
    if (redirect_i) begin
      // Everything still in flight after this cycle, including a coincident gnt, is stale.
      w_discard_next = w_out_next;
      w_state_next   = (w_out_next != '0) ? DRAIN : RUN;
    end else begin
      if (imem_rvalid_i && (r_discard != '0)) begin
        w_discard_next = r_discard - 1'b1;
      end
      case (r_state)
        DRAIN:   if (w_discard_next == '0) w_state_next = RUN;
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      if (redirect_i) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)  r_resp_pc  <= r_resp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + 32),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .wdata_i ({r_resp_pc, imem_rdata_i}),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = !w_fifo_empty;
  assign instr_o       = instr_valid_o ? w_fifo_rdata[31:0] : NOP_INSTR;
  assign instr_pc_o    = instr_valid_o ? w_fifo_rdata[XLEN+31:32] : '0;
  assign opcode_o      = instr_o[6:0];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with an in-bench imem and queue model.
// Config   : honours FETCH_MISALIGN_CHK_EN to match the DUT build.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [6:0]  opcode;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .opcode_o      (opcode),
    .misalign_o    (misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program image: word at 0x0 is 0x000000B3, elsewhere address bits above a cycling opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] opc;
    case (a[4:2])
      3'd0:    opc = 7'b0110011;
      3'd1:    opc = 7'b0000011;
      3'd2:    opc = 7'b0100011;
      3'd3:    opc = 7'b1100011;
      3'd4:    opc = 7'b0010011;
      3'd5:    opc = 7'b1100111;
      3'd6:    opc = 7'b1101111;
      default: opc = 7'b0110111;
    endcase
    return (a == 32'h0) ? 32'h0000_00B3 : {a[24:0], opc};
  endfunction

  // imem environment and reference model
  logic [31:0] pend[$];
  logic [31:0] gaddr[$];
  bit          resp_en;
  logic [63:0] mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  int          m_out;
  int          m_disc;
  bit          m_mis;
  bit          m_g;
  int          m_pre;
  logic [31:0] m_tgt;

  function automatic bit m_req();
    return (rst_n === 1'b1) && (m_disc == 0) && !m_mis && ((mq.size() + m_out) < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mq.delete();
      m_fetch = 32'h0;
      m_resp  = 32'h0;
      m_out   = 0;
      m_disc  = 0;
      m_mis   = 1'b0;
    end else begin
      m_g = m_req() && gnt;
      if (req && gnt) begin
        pend.push_back(addr);
        gaddr.push_back(addr);
      end
      m_out = m_out + (m_g ? 1 : 0) - (rvalid ? 1 : 0);
      if (redirect) begin
        m_tgt = redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        m_mis = (m_tgt[1:0] != 2'b00);
`else
        m_tgt[1:0] = 2'b00;
`endif
        mq.delete();
        m_fetch = m_tgt;
        m_resp  = m_tgt;
        m_disc  = m_out;
      end else begin
        if (m_g) m_fetch = m_fetch + 32'd4;
        m_pre = mq.size();
        if (ready && m_pre > 0) void'(mq.pop_front());
        if (rvalid) begin
          if (m_disc == 0) begin
            check("push_room", (m_pre < DEPTH), 1'b1);
            mq.push_back({m_resp, rdata});
            m_resp = m_resp + 32'd4;
          end else begin
            m_disc = m_disc - 1;
          end
        end
      end
    end
  end

  // Responder: oldest granted address answered no earlier than the next cycle.
  always @(negedge clk) begin
    if (rst_n !== 1'b1 || !resp_en || pend.size() == 0) begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end else begin
      rvalid = 1'b1;
      rdata  = mem_word(pend.pop_front());
    end
  end

  logic        c_req;
  logic [63:0] c_head;
  logic [31:0] c_instr;

  always @(negedge clk) begin
    #2;
    c_req   = m_req();
    c_head  = (mq.size() > 0) ? mq[0] : 64'h0;
    c_instr = (mq.size() > 0) ? c_head[31:0] : NOP;
    check("req", req, c_req);
    if (c_req) check("addr", addr, m_fetch);
    check("valid", valid, (mq.size() > 0));
    check("instr", instr, c_instr);
    check("opcode", opcode, c_instr[6:0]);
    if (mq.size() > 0) check("instr_pc", ipc, c_head[63:32]);
    check("misalign", misalign, m_mis);
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (valid !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    if (valid !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: valid not seen within 20 cycles", name);
    end
  endtask

  task automatic wait_grant(input string name);
    int i;
    i = 0;
    while (gaddr.size() == 0 && i < 20) begin
      tick();
      i++;
    end
    if (gaddr.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
  endtask

  logic [31:0] g0, g1, g2;
  bit          found;

  initial begin
    rst_n = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    resp_en = 1'b1; rvalid = 1'b0; rdata = 32'h0;
    repeat (3) tick();
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_opcode", opcode, 7'b0010011);
    check("rst_misalign", misalign, 1'b0);

    // streaming from reset
    gaddr.delete();
    rst_n = 1'b1;
    wait_valid("t1_valid");
    check("t1_first_pc", ipc, 32'h0);
    check("t1_first_instr", instr, 32'h0000_00B3);
    check("t1_first_opcode", opcode, 7'b0110011);
    repeat (12) tick();
    g0 = gaddr[0]; g1 = gaddr[1]; g2 = gaddr[2];
    check("t1_grant0", g0, 32'h0);
    check("t1_grant1", g1, 32'h4);
    check("t1_grant2", g2, 32'h8);

    // decode stalled: credit limits to two requests
    reset_pulse();
    ready = 1'b0;
    gaddr.delete();
    rst_n = 1'b1;
    repeat (8) tick();
    check("t2_grants", gaddr.size(), 2);
    check("t2_req_low", req, 1'b0);
    check("t2_valid", valid, 1'b1);
    check("t2_head_pc", ipc, 32'h0);
    ready = 1'b1;
    gaddr.delete();
    wait_grant("t2_resume");
    g0 = gaddr[0];
    check("t2_resume_addr", g0, 32'h8);

    // grant withheld: address holds
    reset_pulse();
    gnt = 1'b0;
    gaddr.delete();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("t3_req_held", req, 1'b1);
      check("t3_addr_held", addr, 32'h0);
    end
    check("t3_no_grant", gaddr.size(), 0);
    gnt = 1'b1;
    wait_grant("t3_grant");
    g0 = gaddr[0];
    check("t3_grant_addr", g0, 32'h0);
    repeat (4) tick();

    // redirect with two outstanding requests
    reset_pulse();
    resp_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t4_credit_full", req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    gaddr.delete();
    check("t4_drain_req", req, 1'b0);
    check("t4_flushed", valid, 1'b0);
    resp_en = 1'b1;
    wait_grant("t4_grant");
    g0 = gaddr[0];
    check("t4_new_addr", g0, 32'h100);
    wait_valid("t4_valid");
    check("t4_first_pc", ipc, 32'h100);

    // redirect coincident with gnt and rvalid
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (req && rvalid) found = 1'b1;
    end
    check("t5_coincide_found", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    wait_valid("t5_valid");
    check("t5_first_pc", ipc, 32'h200);
    repeat (6) tick();

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    gaddr.delete();
`ifdef FETCH_MISALIGN_CHK_EN
    check("t6_misalign_set", misalign, 1'b1);
    check("t6_req_blocked", req, 1'b0);
    repeat (4) tick();
    check("t6_still_empty", valid, 1'b0);
    check("t6_no_grant", gaddr.size(), 0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    gaddr.delete();
    check("t6_misalign_clr", misalign, 1'b0);
    wait_grant("t6_grant");
    g0 = gaddr[0];
    check("t6_resume_addr", g0, 32'h200);
`else
    check("t6_no_misalign", misalign, 1'b0);
    wait_grant("t6_grant");
    g0 = gaddr[0];
    check("t6_forced_align", g0, 32'h100);
`endif
    repeat (4) tick();

    // reset asserted while draining
    reset_pulse();
    resp_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("t7_in_drain", req, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t7_rst_req", req, 1'b0);
    check("t7_rst_addr", addr, 32'h0);
    check("t7_rst_valid", valid, 1'b0);
    check("t7_rst_instr", instr, 32'h0000_0013);
    check("t7_rst_opcode", opcode, 7'b0010011);
    check("t7_rst_misalign", misalign, 1'b0);
    tick();
    resp_en = 1'b1;
    rst_n = 1'b1;
    wait_valid("t7_valid");
    check("t7_restart_pc", ipc, 32'h0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
